// File: rtl/dec_mul_seq_if.sv
// rtl/dec_mul_seq_if.sv - operand/product handshake bundle for the sequential BCD multiplier
interface dec_mul_seq_if #(
    parameter int N_DIGITS = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4*N_DIGITS-1:0]   x_bcd;
    logic [4*N_DIGITS-1:0]   y_bcd;
    logic                    out_valid;
    logic                    out_ready;
    logic [8*N_DIGITS-1:0]   z_bcd;
    logic                    out_err;

    // Operand loader / result formatter side
    modport master (
        output in_valid,
        output x_bcd,
        output y_bcd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  z_bcd,
        input  out_err
    );

    // Multiplier side
    modport slave (
        input  in_valid,
        input  x_bcd,
        input  y_bcd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output z_bcd,
        output out_err
    );
endinterface

// File: rtl/dec_mul_seq.sv
// rtl/dec_mul_seq.sv - sequential N-digit BCD multiplier: digit-MAC convolution then serial carry pass
module dec_mul_seq #(
    parameter int N_DIGITS = 4,
    parameter int ACC_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    dec_mul_seq_if.slave  s
);

    localparam int NZ    = 2 * N_DIGITS;
    localparam int IDX_W = (NZ > 1) ? $clog2(NZ) : 1;

    localparam logic [IDX_W-1:0] LAST_IJ = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(NZ - 1);

    // Reject parameter sets where a column sum plus incoming carry could overflow
    if (N_DIGITS < 1) begin : g_bad_n
        $error("dec_mul_seq: N_DIGITS must be at least 1");
    end
    if ((ACC_W < 32) && ((64'd1 << ACC_W) <= 64'(90 * N_DIGITS))) begin : g_bad_acc
        $error("dec_mul_seq: ACC_W too narrow for 81*N_DIGITS + 9*N_DIGITS");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        CARRY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q,     state_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   err_q,       err_d;
    logic [4*N_DIGITS-1:0]  x_q,         x_d;
    logic [4*N_DIGITS-1:0]  y_q,         y_d;
    logic [ACC_W-1:0]       acc_q [NZ];
    logic [ACC_W-1:0]       acc_d [NZ];
    logic [IDX_W-1:0]       i_q,         i_d;
    logic [IDX_W-1:0]       j_q,         j_d;
    logic [IDX_W-1:0]       k_q,         k_d;
    logic [ACC_W-1:0]       carry_q,     carry_d;
    logic [8*N_DIGITS-1:0]  z_q,         z_d;

    // Shared digit MAC operands and the mod-10 carry stage
    logic [3:0]             x_dig;
    logic [3:0]             y_dig;
    logic [ACC_W-1:0]       prod;
    logic [IDX_W-1:0]       pos;
    logic [ACC_W-1:0]       t_sum;
    logic [3:0]             t_mod;
    logic [ACC_W-1:0]       t_div;

    assign x_dig = x_q[4*i_q +: 4];
    assign y_dig = y_q[4*j_q +: 4];
    assign prod  = ACC_W'({4'b0000, x_dig} * {4'b0000, y_dig});
    assign pos   = i_q + j_q;
    assign t_sum = acc_q[k_q] + carry_q;
    assign t_mod = 4'(t_sum % ACC_W'(10));
    assign t_div = t_sum / ACC_W'(10);

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.z_bcd     = z_q;
    assign s.out_err   = err_q;

    function automatic logic has_bad_digit(input logic [4*N_DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Next-state and datapath: accept, convolve one digit pair per cycle, propagate carries, hold result
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        carry_d     = carry_q;
        z_d         = z_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (s.in_valid && in_ready_q) begin
                    x_d        = s.x_bcd;
                    y_d        = s.y_bcd;
                    err_d      = has_bad_digit(s.x_bcd) | has_bad_digit(s.y_bcd);
                    acc_d      = '{default: '0};
                    i_d        = '0;
                    j_d        = '0;
                    k_d        = '0;
                    carry_d    = '0;
                    z_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = CONV;
                end
            end

            CONV: begin
                acc_d[pos] = acc_q[pos] + prod;
                if (j_q == LAST_IJ) begin
                    j_d = '0;
                    if (i_q == LAST_IJ) begin
                        i_d     = '0;
                        k_d     = '0;
                        carry_d = '0;
                        state_d = CARRY;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end

            CARRY: begin
                // An invalid operand still walks every position so timing matches the normal path
                z_d[4*k_q +: 4] = err_q ? 4'd0 : t_mod;
                carry_d         = t_div;
                if (k_q == LAST_K) begin
                    k_d         = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            DONE: begin
                if (s.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight product
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '{default: '0};
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            carry_q     <= '0;
            z_q         <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            x_q         <= x_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            z_q         <= z_d;
        end
    end

endmodule

// File: tb/tb_dec_mul_seq.sv
// tb/tb_dec_mul_seq.sv - directed self-checking bench for dec_mul_seq at N=4, N=8 and N=1
module tb_dec_mul_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dec_mul_seq_if #(.N_DIGITS(4)) i4 ();
    dec_mul_seq_if #(.N_DIGITS(8)) i8 ();
    dec_mul_seq_if #(.N_DIGITS(1)) i1 ();

    dec_mul_seq #(.N_DIGITS(4), .ACC_W(16)) u_dut4 (.clk(clk), .rst(rst), .s(i4));
    dec_mul_seq #(.N_DIGITS(8), .ACC_W(16)) u_dut8 (.clk(clk), .rst(rst), .s(i8));
    dec_mul_seq #(.N_DIGITS(1), .ACC_W(16)) u_dut1 (.clk(clk), .rst(rst), .s(i1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for the accepting edge, then scramble the inputs
    task automatic start4(input logic [15:0] x, input logic [15:0] y);
        i4.x_bcd    = x;
        i4.y_bcd    = y;
        i4.in_valid = 1'b1;
        tick();
        i4.in_valid = 1'b0;
        i4.x_bcd    = 16'h9876;
        i4.y_bcd    = 16'h5432;
    endtask

    task automatic wait4(output int n);
        n = 0;
        while (i4.out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int  n;
        logic bad;

        rst          = 1'b1;
        i4.in_valid  = 1'b0; i4.x_bcd = '0; i4.y_bcd = '0; i4.out_ready = 1'b1;
        i8.in_valid  = 1'b0; i8.x_bcd = '0; i8.y_bcd = '0; i8.out_ready = 1'b1;
        i1.in_valid  = 1'b0; i1.x_bcd = '0; i1.y_bcd = '0; i1.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        chk("reset_in_ready",  64'(i4.in_ready),  64'd1);
        chk("reset_out_valid", 64'(i4.out_valid), 64'd0);
        chk("reset_z",         64'(i4.z_bcd),     64'd0);
        chk("reset_err",       64'(i4.out_err),   64'd0);

        // 1234 * 5678 = 7006652
        start4(16'h1234, 16'h5678);
        chk("accept_in_ready_low", 64'(i4.in_ready), 64'd0);
        wait4(n);
        chk("t1_latency", 64'(n), 64'd24);
        chk("t1_z",   64'(i4.z_bcd),   64'h07006652);
        chk("t1_err", 64'(i4.out_err), 64'd0);
        tick();
        chk("t1_hs_out_valid", 64'(i4.out_valid), 64'd0);
        chk("t1_hs_in_ready",  64'(i4.in_ready),  64'd1);

        // Longest carry chain, then back-to-back zero operand
        start4(16'h9999, 16'h9999);
        wait4(n);
        chk("t2_latency", 64'(n), 64'd24);
        chk("t2_z", 64'(i4.z_bcd), 64'h99980001);
        tick();
        chk("t2_hs_in_ready", 64'(i4.in_ready), 64'd1);
        start4(16'h0000, 16'h9999);
        wait4(n);
        chk("t3_latency", 64'(n), 64'd24);
        chk("t3_z", 64'(i4.z_bcd), 64'h00000000);
        tick();

        // Backpressure: product held for 50 cycles
        i4.out_ready = 1'b0;
        start4(16'h0001, 16'h0001);
        wait4(n);
        chk("bp_latency", 64'(n), 64'd24);
        chk("bp_z", 64'(i4.z_bcd), 64'h00000001);
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (i4.z_bcd !== 32'h00000001 || i4.in_ready !== 1'b0 || i4.out_valid !== 1'b1) begin
                bad = 1'b1;
            end
        end
        chk("bp_stable", 64'(bad), 64'd0);
        i4.out_ready = 1'b1;
        tick();
        i4.out_ready = 1'b0;
        chk("bp_release_out_valid", 64'(i4.out_valid), 64'd0);
        chk("bp_release_in_ready",  64'(i4.in_ready),  64'd1);
        tick();
        chk("bp_single_hs", 64'(i4.out_valid), 64'd0);
        i4.out_ready = 1'b1;

        // Invalid digit in X forces zero product with error flag
        start4(16'h00A0, 16'h1111);
        wait4(n);
        chk("err_latency", 64'(n), 64'd24);
        chk("err_flag", 64'(i4.out_err), 64'd1);
        chk("err_z", 64'(i4.z_bcd), 64'd0);
        tick();

        // Reset during convolution
        start4(16'h4321, 16'h8765);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_conv_in_ready",  64'(i4.in_ready),  64'd1);
        chk("rst_conv_out_valid", 64'(i4.out_valid), 64'd0);

        // Reset during the carry pass
        start4(16'h4321, 16'h8765);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_carry_in_ready",  64'(i4.in_ready),  64'd1);
        chk("rst_carry_out_valid", 64'(i4.out_valid), 64'd0);
        chk("rst_carry_z",         64'(i4.z_bcd),     64'd0);

        start4(16'h0012, 16'h0034);
        wait4(n);
        chk("fresh_latency", 64'(n), 64'd24);
        chk("fresh_z", 64'(i4.z_bcd), 64'h00000408);
        tick();

        // N=8: 99999999^2
        i8.x_bcd    = 32'h99999999;
        i8.y_bcd    = 32'h99999999;
        i8.in_valid = 1'b1;
        tick();
        i8.in_valid = 1'b0;
        n = 0;
        while (i8.out_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("n8_latency", 64'(n), 64'd80);
        chk("n8_z", 64'(i8.z_bcd), 64'h9999999800000001);
        tick();

        // N=1: 9*9
        i1.x_bcd    = 4'h9;
        i1.y_bcd    = 4'h9;
        i1.in_valid = 1'b1;
        tick();
        i1.in_valid = 1'b0;
        n = 0;
        while (i1.out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("n1_latency", 64'(n), 64'd3);
        chk("n1_z", 64'(i1.z_bcd), 64'h81);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_mul_seq.md
Name: dec_mul_seq

Overview:
- Sequential, parametrised successor to the combinational 4x4-digit decimal multiplier.
- Multiplies two N-digit non-negative BCD integers and returns the exact 2N-digit BCD product.
- Uses one shared digit MAC for schoolbook convolution, then a serial mod-10 carry pass. The result is exact; there is no fixed-point transform rounding.
- Sits between the operand loader and the result formatter, with valid/ready on both sides.

Parameters:
- N_DIGITS, 4, digits per operand (>=1); product has 2*N_DIGITS digits.
- ACC_W, 16, per-position accumulator width. Must satisfy 2^ACC_W > 81*N_DIGITS + 9*N_DIGITS, which covers the largest partial sum plus the largest incoming carry. Elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- x_bcd  in  4*N_DIGITS  operand X; bits [4k+3:4k] hold the digit of weight 10^k
- y_bcd  in  4*N_DIGITS  operand Y; same packing as x_bcd
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- z_bcd  out  8*N_DIGITS  product; bits [4k+3:4k] hold the digit of weight 10^k
- out_err  out  1  qualified by out_valid; 1 = an input digit was >9

Behaviour:
- States: IDLE, CONV, CARRY, DONE.
- Reset (rst=1 at an edge) forces IDLE from any state, including mid-CONV/CARRY. The partial result is discarded.
  - Reset values: in_ready=1, out_valid=0, z_bcd=0, out_err=0.
  - Accumulators, counters and carry register cleared to 0.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register x_bcd and y_bcd; clear acc[0..2N-1] and i=j=0; go to CONV.
  - Set err if any digit of either operand is >9.
- CONV:
  - in_ready=0.
  - Each cycle: acc[i+j] += x[i]*y[j]. Each product is 7 bits wide and is zero-extended to ACC_W.
  - j increments; when j wraps from N-1 to 0, i increments.
  - After the (i=N-1, j=N-1) cycle, go to CARRY with k=0 and carry=0.
  - Takes exactly N*N cycles.
- CARRY:
  - Each cycle: t = acc[k] + carry; z digit k = t mod 10; carry = t div 10; k++.
  - Division by constant 10 is combinational; it needs no extra cycle.
  - After k=2N-1, go to DONE.
  - Takes exactly 2N cycles. The final carry is always 0 because the product fits in 2N digits.
- DONE:
  - out_valid=1; z_bcd and out_err are held stable while out_ready=0 (backpressure indefinite).
  - On out_valid && out_ready: go to IDLE and drop out_valid.
  - in_ready returns to 1 on the following cycle; there is no overlap of input and output handshakes.
- Latency: out_valid rises N*N + 2N clock edges after the accepting edge. For N=4 that is 24 edges.
- Throughput: one product per N*N + 2N + 2 cycles when out_ready is held high.
- Error handling:
  - When err is set, z_bcd is forced to all zeros and out_err=1 in DONE.
  - Timing is identical to the normal path.
- Inputs x_bcd and y_bcd are ignored outside the accepting cycle; changing them mid-operation has no effect.
- in_valid may be held high continuously; a new operand pair is accepted only in IDLE.

Test Plan:
- N=4, x=1234, y=5678 -> out_valid exactly 24 edges after accept; z_bcd=0x00007006652 digit pattern (07006652); out_err=0.
- N=4, x=9999, y=9999 (max carry chain) -> z=99980001. Also x=0, y=9999 -> z=00000000. Both with out_ready held high, the second accepted 2 cycles after the first completes.
- Backpressure: x=0001, y=0001, out_ready=0 for 50 cycles after out_valid -> z=00000001 stable and in_ready=0 throughout; release -> single handshake, in_ready=1 next cycle.
- Invalid digit: x digit 1 = 0xA, y=1111 -> out_err=1, z=0, same 24-edge latency.
- Reset mid-CONV (cycle 7) and mid-CARRY (cycle 20) -> next cycle in_ready=1, out_valid=0; a fresh 0012*0034 then yields 00000408.
- N=8, ACC_W=16, x=y=99999999 -> z=9999999800000001 after 80 edges; N=1, x=9, y=9 -> z=81 after 3 edges.
